// File: rtl/ascii_int_pkg.sv
// Shared constants and types for the ascii_int counter chain and its serializer.
package ascii_int_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_CR,
        ST_LF
    } ser_state_e;

    // Index width for a chain of n digits, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ascii_int_serializer_if.sv
// Start/digit inputs and byte-stream handshake between the serializer and its sink.
interface ascii_int_serializer_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [8*DIGITS-1:0]   digits;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, digits, out_ready,
        output out_data, out_valid, busy, done
    );

    modport slave (
        output start, digits, out_ready,
        input  out_data, out_valid, busy, done
    );
endinterface

// File: rtl/ascii_int_serializer_lz_index.sv
// Priority encoder: index of the first digit to send, optionally skipping leading '0's.
module ascii_lz_index
    import ascii_int_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter bit          SUPPRESS_ZEROS = 1'b1,
    localparam int unsigned IW            = idx_width(DIGITS)
) (
    input  logic [8*DIGITS-1:0] digits,
    output logic [IW-1:0]       start_idx_c
);

    // Ascending scan so the highest non-'0' digit wins; digit 0 is always sent.
    always_comb begin
        start_idx_c = IW'(DIGITS - 1);
        if (SUPPRESS_ZEROS) begin
            start_idx_c = '0;
            for (int unsigned i = 1; i < DIGITS; i++) begin
                if (digits[8*i +: 8] != ASCII_ZERO) begin
                    start_idx_c = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ascii_int_serializer.sv
// Snapshots an ascii_int digit chain on start and streams it MSD first with valid/ready.
module ascii_int_serializer
    import ascii_int_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter bit          SUPPRESS_ZEROS = 1'b1,
    parameter bit          TERMINATOR     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    ascii_int_serializer_if.master bus
);

    localparam int unsigned IW    = idx_width(DIGITS);
    localparam int unsigned SLOTS = 1 << IW;

    ser_state_e             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [SLOTS-1:0][7:0]  snap_q, snap_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IW-1:0]          start_idx_c;
    logic                   hs_c;
    logic                   finish_c;

    ascii_lz_index #(
        .DIGITS         (DIGITS),
        .SUPPRESS_ZEROS (SUPPRESS_ZEROS)
    ) u_lz_index (
        .digits      (bus.digits),
        .start_idx_c (start_idx_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next byte is preloaded into out_data so consecutive bytes flow without a bubble.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        finish_c    = 1'b0;
        hs_c        = out_valid_q & bus.out_ready;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                out_data_d  = '0;
                if (bus.start) begin
                    snap_d              = '0;
                    snap_d[DIGITS-1:0]  = bus.digits;
                    idx_d               = start_idx_c;
                    out_data_d          = snap_d[start_idx_c];
                    out_valid_d         = 1'b1;
                    busy_d              = 1'b1;
                    state_d             = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (hs_c) begin
                    if (idx_q != '0) begin
                        idx_d      = idx_q - IW'(1);
                        out_data_d = snap_q[idx_q - IW'(1)];
                    end else if (TERMINATOR) begin
                        state_d    = ST_CR;
                        out_data_d = ASCII_CR;
                    end else begin
                        finish_c   = 1'b1;
                    end
                end
            end
            ST_CR: begin
                if (hs_c) begin
                    state_d    = ST_LF;
                    out_data_d = ASCII_LF;
                end
            end
            ST_LF: begin
                if (hs_c) begin
                    finish_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish_c) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ascii_int_serializer.sv
// Self-checking bench: three serializer configurations against a queue-based frame model.
module tb_ascii_int_serializer;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] dig = '0;
    int          sel = 0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // a: 4 digits, suppress, CR/LF   b: 4 digits, no suppress, CR/LF   c: 1 digit, no terminator
    ascii_int_serializer_if #(.DIGITS(4)) if_a ();
    ascii_int_serializer_if #(.DIGITS(4)) if_b ();
    ascii_int_serializer_if #(.DIGITS(1)) if_c ();

    assign if_a.start = start && (sel == 0);
    assign if_b.start = start && (sel == 1);
    assign if_c.start = start && (sel == 2);
    assign if_a.digits = dig;
    assign if_b.digits = dig;
    assign if_c.digits = dig[7:0];
    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign if_c.out_ready = out_ready;

    ascii_int_serializer #(.DIGITS(4), .SUPPRESS_ZEROS(1'b1), .TERMINATOR(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a));
    ascii_int_serializer #(.DIGITS(4), .SUPPRESS_ZEROS(1'b0), .TERMINATOR(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b));
    ascii_int_serializer #(.DIGITS(1), .SUPPRESS_ZEROS(1'b1), .TERMINATOR(1'b0)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c));

    logic [7:0] m_data;
    logic       m_valid, m_busy, m_done;

    always_comb begin
        m_data = if_a.out_data; m_valid = if_a.out_valid; m_busy = if_a.busy; m_done = if_a.done;
        case (sel)
            1: begin m_data = if_b.out_data; m_valid = if_b.out_valid; m_busy = if_b.busy; m_done = if_b.done; end
            2: begin m_data = if_c.out_data; m_valid = if_c.out_valid; m_busy = if_c.busy; m_done = if_c.done; end
            default: ;
        endcase
    end

    // Reference frame: digits MSD first, strip leading '0' keeping at least one, then CR LF.
    function automatic byte_q_t model(input logic [31:0] dg, input int nd, input bit sz, input bit term);
        byte_q_t q;
        for (int i = nd - 1; i >= 0; i--) q.push_back(dg[8*i +: 8]);
        if (sz) while (q.size() > 1 && q[0] == 8'h30) void'(q.pop_front());
        if (term) begin q.push_back(8'h0D); q.push_back(8'h0A); end
        return q;
    endfunction

    function automatic byte_q_t model_sel(input int s, input logic [31:0] dg);
        case (s)
            1:       return model(dg, 4, 1'b0, 1'b1);
            2:       return model(dg, 1, 1'b1, 1'b0);
            default: return model(dg, 4, 1'b1, 1'b1);
        endcase
    endfunction

    function automatic bit q_eq(input byte_q_t a, input byte_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input byte_q_t q);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
        return s;
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 3) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rand_digits();
        logic [31:0] d;
        int r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      d[8*i +: 8] = 8'h30;
            else if (r < 9) d[8*i +: 8] = 8'h30 + 8'($urandom_range(0, 9));
            else            d[8*i +: 8] = 8'($urandom);
        end
        return d;
    endfunction

    // Observations of the most recent frame.
    byte_q_t got;
    int      busy_cycles, done_cycle, last_hs_cycle, hold_bad;
    logic    first_valid, first_busy, busy_at_done, done_after, extra_valid;
    bit      timed_out;

    task automatic run_frame(input int s, input logic [31:0] dg, input int rmode,
                             input bit live, input bit poke);
        logic [7:0] pd;
        logic       pv, pr;
        int         cyc;
        got.delete();
        busy_cycles = 0; done_cycle = -1; last_hs_cycle = -1; hold_bad = 0; timed_out = 1'b0;
        sel = s; dig = dg; start = 1'b1; out_ready = 1'b0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        @(posedge clk); #1;
        start = 1'b0;
        first_valid = m_valid;
        first_busy  = m_busy;
        cyc = 0;
        forever begin
            if (cyc > 200) begin timed_out = 1'b1; break; end
            if (m_done) begin done_cycle = cyc; busy_at_done = m_busy; break; end
            if (m_busy) busy_cycles++;
            if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) hold_bad++;
            out_ready = rdy(rmode, cyc);
            if (m_valid && out_ready) begin got.push_back(m_data); last_hs_cycle = cyc; end
            pv = m_valid; pd = m_data; pr = out_ready;
            if (live) dig = $urandom;
            start = poke && (cyc == 1);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        done_after  = m_done;
        extra_valid = m_valid;
        @(posedge clk); #1;
        extra_valid = extra_valid | m_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_busy  !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        checks++; if (m_done  !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", m_done); end
        checks++; if (m_data  !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", m_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        byte_q_t exp;
        exp = model_sel(0, 32'h3030_3432);
        run_frame(0, 32'h3030_3432, 0, 1'b0, 1'b0);
        checks++; if (timed_out) begin fails++; $display("FAIL basic_timeout: got no done want done"); end
        checks++; if (first_valid !== 1'b1 || first_busy !== 1'b1) begin fails++;
            $display("FAIL basic_latency: got valid=%b busy=%b want 1 1", first_valid, first_busy); end
        checks++; if (!q_eq(got, exp)) begin fails++;
            $display("FAIL basic_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
        checks++; if (busy_cycles !== 4) begin fails++; $display("FAIL basic_busy_len: got %0d want 4", busy_cycles); end
        checks++; if (done_cycle !== last_hs_cycle + 1 || busy_at_done !== 1'b0) begin fails++;
            $display("FAIL basic_done: got cycle %0d busy %b want cycle %0d busy 0", done_cycle, busy_at_done, last_hs_cycle + 1); end
        checks++; if (done_after !== 1'b0 || extra_valid !== 1'b0) begin fails++;
            $display("FAIL basic_done_width: got done=%b valid=%b want 0 0", done_after, extra_valid); end
    endtask

    task automatic test_all_zero();
        byte_q_t exp;
        exp = model_sel(0, 32'h3030_3030);
        run_frame(0, 32'h3030_3030, 0, 1'b0, 1'b0);
        checks++; if (!q_eq(got, exp) || timed_out) begin fails++;
            $display("FAIL zero_suppress: got [%s] want [%s]", q2s(got), q2s(exp)); end
        exp = model_sel(1, 32'h3030_3030);
        run_frame(1, 32'h3030_3030, 0, 1'b0, 1'b0);
        checks++; if (!q_eq(got, exp) || timed_out) begin fails++;
            $display("FAIL zero_nosuppress: got [%s] want [%s]", q2s(got), q2s(exp)); end
        checks++; if (busy_cycles !== 6) begin fails++; $display("FAIL zero_nosuppress_busy: got %0d want 6", busy_cycles); end
    endtask

    task automatic test_backpressure();
        byte_q_t exp;
        exp = model_sel(0, 32'h3939_3939);
        run_frame(0, 32'h3939_3939, 1, 1'b0, 1'b0);
        checks++; if (!q_eq(got, exp) || timed_out) begin fails++;
            $display("FAIL bp_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
        checks++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
        checks++; if (done_cycle !== last_hs_cycle + 1) begin fails++;
            $display("FAIL bp_done: got cycle %0d want %0d", done_cycle, last_hs_cycle + 1); end
    endtask

    task automatic test_snapshot();
        byte_q_t exp;
        exp = model_sel(0, 32'h3031_3233);
        run_frame(0, 32'h3031_3233, 0, 1'b1, 1'b1);
        checks++; if (!q_eq(got, exp) || timed_out) begin fails++;
            $display("FAIL snapshot_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
        checks++; if (extra_valid !== 1'b0) begin fails++;
            $display("FAIL snapshot_no_requeue: got valid=%b after done want 0", extra_valid); end
    endtask

    task automatic test_reset_mid();
        byte_q_t exp;
        sel = 0; dig = 32'h3031_3233; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin fails++;
            $display("FAIL midrst_idle: got valid=%b busy=%b done=%b want 0 0 0", m_valid, m_busy, m_done); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0 || m_done !== 1'b0) begin fails++;
            $display("FAIL midrst_no_resume: got valid=%b done=%b want 0 0", m_valid, m_done); end
        exp = model_sel(0, 32'h3031_3233);
        run_frame(0, 32'h3031_3233, 0, 1'b0, 1'b0);
        checks++; if (!q_eq(got, exp) || timed_out) begin fails++;
            $display("FAIL midrst_refresh: got [%s] want [%s]", q2s(got), q2s(exp)); end
    endtask

    task automatic test_single_digit();
        byte_q_t exp;
        exp = model_sel(2, 32'h0000_0037);
        run_frame(2, 32'h0000_0037, 0, 1'b0, 1'b0);
        checks++; if (!q_eq(got, exp) || timed_out || done_cycle !== 1) begin fails++;
            $display("FAIL single_frame: got [%s] done@%0d want [%s] done@1", q2s(got), done_cycle, q2s(exp)); end
        // start held high: next frame is accepted in the done cycle
        sel = 2; dig = 32'h0000_0037; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h37) begin fails++;
            $display("FAIL hold_first: got valid=%b data=%h want 1 37", m_valid, m_data); end
        @(posedge clk); #1;
        checks++; if (m_done !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b0) begin fails++;
            $display("FAIL hold_done: got done=%b valid=%b busy=%b want 1 0 0", m_done, m_valid, m_busy); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h37 || m_busy !== 1'b1) begin fails++;
            $display("FAIL hold_restart: got valid=%b data=%h busy=%b want 1 37 1", m_valid, m_data, m_busy); end
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (m_done !== 1'b1) begin fails++; $display("FAIL hold_done2: got %b want 1", m_done); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0 || m_done !== 1'b0) begin fails++;
            $display("FAIL hold_quiet: got valid=%b done=%b want 0 0", m_valid, m_done); end
    endtask

    task automatic test_random();
        byte_q_t     exp;
        int          s;
        logic [31:0] d;
        for (int n = 0; n < 24; n++) begin
            s = $urandom_range(0, 2);
            d = rand_digits();
            exp = model_sel(s, d);
            run_frame(s, d, $urandom_range(0, 2), 1'b0, 1'b0);
            checks++; if (!q_eq(got, exp) || timed_out) begin fails++;
                $display("FAIL rand_frame[%0d] cfg%0d: got [%s] want [%s]", n, s, q2s(got), q2s(exp)); end
            checks++; if (hold_bad !== 0 || done_cycle !== last_hs_cycle + 1) begin fails++;
                $display("FAIL rand_flow[%0d] cfg%0d: got hold_bad=%0d done@%0d want 0 done@%0d",
                         n, s, hold_bad, done_cycle, last_hs_cycle + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_backpressure();
        test_snapshot();
        test_reset_mid();
        test_single_digit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
